dvp_capture_ctrl: RTL and testbench

//  Frame-capture sequencer between the DVP receiver AXIS output (line-based, TUSER=SOF, TLAST=EOL, no TREADY) and the

---
 rtl/dvp_capture_ctrl_pkg.sv | 23 ++
 rtl/dvp_axis_out_reg.sv | 34 +++
 rtl/dvp_capture_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_dvp_capture_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_capture_ctrl_pkg.sv
// Shared types and default widths for the DVP frame-capture sequencer.
// Optional frame decimation is enabled with DVP_CAPTURE_DECIM_EN.
package dvp_pkg;

  localparam int LW_DEF = 12;
  localparam int FW_DEF = 11;
  localparam int CW_DEF = 16;
  localparam int BEAT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_ABORT
  } state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } dvp_beat_t;

endpackage

// File: rtl/dvp_axis_out_reg.sv
// One-entry AXIS output register; full_o lets the sequencer detect overflow,
// since the upstream DVP source has no back-pressure.
module dvp_axis_out_reg
  import dvp_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [BEAT_W-1:0] beat_i,
  input  logic              ready_i,
  output logic              full_o,
  output logic [BEAT_W-1:0] beat_o
);

  dvp_beat_t beat_q;
  logic      full_q;

  // Caller only loads when empty or draining, so a held beat never changes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      beat_q <= '0;
    end else if (load_i) begin
      full_q <= 1'b1;
      beat_q <= dvp_beat_t'(beat_i);
    end else if (ready_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign beat_o = beat_q;

endmodule

// File: rtl/dvp_capture_ctrl.sv
// Frame-capture sequencer: arms on command, gates whole frames from SOF, checks
// line/frame geometry and flags overflow. DVP_CAPTURE_DECIM_EN adds cfg_decim.
module dvp_capture_ctrl
  import dvp_pkg::*;
#(
  parameter int LW = LW_DEF,
  parameter int FW = FW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          pclk,
  input  logic          aresetn,
  input  logic [7:0]    s_tdata,
  input  logic          s_tvalid,
  input  logic          s_tlast,
  input  logic          s_tuser,
  output logic [7:0]    m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic          m_tuser,
  input  logic          cmd_start,
  input  logic          cmd_stop,
  input  logic          cfg_continuous,
  input  logic [LW-1:0] cfg_line_bytes,
  input  logic [FW-1:0] cfg_frame_lines,
`ifdef DVP_CAPTURE_DECIM_EN
  input  logic [3:0]    cfg_decim,
`endif
  input  logic          err_clr,
  output logic          busy,
  output logic          frame_done,
  output logic [CW-1:0] frame_count,
  output logic          err_line_len,
  output logic          err_short_frame,
  output logic          err_overflow
);

  state_e        state_q;
  logic          stop_pending_q;
  logic [LW-1:0] byte_cnt_q, line_bytes_q;
  logic [FW-1:0] line_cnt_q, frame_lines_q;
  logic [CW-1:0] frame_count_q;
  logic          frame_done_q, err_line_len_q, err_short_frame_q, err_overflow_q;

  logic          ob_full;
  dvp_beat_t     in_beat, out_beat;
  logic          sof, stop_now, can_load, want, accept, ovf, eol;
  logic          frame_end, len_err, short_err, rearm, skip_ok;
  logic [LW-1:0] byte_base, byte_new, lb_eff;
  logic [FW-1:0] line_base, fl_eff;
  state_e        after_accept;

  assign in_beat  = '{data: s_tdata, last: s_tlast, user: s_tuser};
  assign sof      = s_tvalid & s_tuser;
  assign stop_now = stop_pending_q | cmd_stop;
  assign can_load = ~ob_full | m_tready;

  always_comb begin
    want = 1'b0;
    case (state_q)
      ST_ARMED:   want = sof & ~cmd_stop & skip_ok;
      ST_CAPTURE: want = s_tvalid;
      ST_ABORT:   want = sof & ~stop_now;
      default:    want = 1'b0;
    endcase
  end

  assign accept = want & can_load;
  assign ovf    = want & ~can_load;
  assign eol    = accept & s_tlast;

  // An SOF beat restarts geometry tracking and uses the freshly sampled config.
  assign byte_base = sof ? '0 : byte_cnt_q;
  assign line_base = sof ? '0 : line_cnt_q;
  assign lb_eff    = sof ? cfg_line_bytes : line_bytes_q;
  assign fl_eff    = sof ? cfg_frame_lines : frame_lines_q;
  assign byte_new  = byte_base + LW'(1);

  assign frame_end    = eol & (line_base == fl_eff - FW'(1));
  assign len_err      = eol & (byte_new != lb_eff);
  assign short_err    = accept & sof & (state_q == ST_CAPTURE);
  assign rearm        = cfg_continuous & ~stop_now;
  assign after_accept = frame_end ? (rearm ? ST_ARMED : ST_IDLE) : ST_CAPTURE;

`ifdef DVP_CAPTURE_DECIM_EN
  logic [3:0] skip_q;

  assign skip_ok = (skip_q == 4'd0);

  // Counts down the frames still to be skipped before the next capture.
  always_ff @(posedge pclk or negedge aresetn) begin
    if (!aresetn) begin
      skip_q <= 4'd0;
    end else if (state_q == ST_IDLE && cmd_start) begin
      skip_q <= 4'd0;
    end else if (state_q == ST_ARMED && sof && !cmd_stop) begin
      if (!skip_ok)    skip_q <= skip_q - 4'd1;
      else if (accept) skip_q <= cfg_decim;
    end
  end
`else
  assign skip_ok = 1'b1;
`endif

  always_ff @(posedge pclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q           <= ST_IDLE;
      stop_pending_q    <= 1'b0;
      byte_cnt_q        <= '0;
      line_cnt_q        <= '0;
      line_bytes_q      <= '0;
      frame_lines_q     <= '0;
      frame_count_q     <= '0;
      frame_done_q      <= 1'b0;
      err_line_len_q    <= 1'b0;
      err_short_frame_q <= 1'b0;
      err_overflow_q    <= 1'b0;
    end else begin
      frame_done_q      <= frame_end;
      err_line_len_q    <= (err_line_len_q & ~err_clr) | len_err;
      err_short_frame_q <= (err_short_frame_q & ~err_clr) | short_err;
      err_overflow_q    <= (err_overflow_q & ~err_clr) | ovf;
      if (frame_end) frame_count_q <= frame_count_q + CW'(1);

      if (accept) begin
        if (sof) begin
          line_bytes_q  <= cfg_line_bytes;
          frame_lines_q <= cfg_frame_lines;
        end
        if (eol) begin
          byte_cnt_q <= '0;
          line_cnt_q <= frame_end ? '0 : line_base + FW'(1);
        end else begin
          byte_cnt_q <= byte_new;
          line_cnt_q <= line_base;
        end
      end

      case (state_q)
        ST_IDLE: begin
          stop_pending_q <= 1'b0;
          if (cmd_start && !cmd_stop) state_q <= ST_ARMED;
        end
        ST_ARMED: begin
          if (cmd_stop)               state_q <= ST_IDLE;
          else if (accept)            state_q <= after_accept;
          else if (ovf)               state_q <= ST_ABORT;
        end
        ST_CAPTURE: begin
          if (cmd_stop) stop_pending_q <= 1'b1;
          if (ovf)                    state_q <= ST_ABORT;
          else if (accept)            state_q <= after_accept;
        end
        ST_ABORT: begin
          if (cmd_stop) stop_pending_q <= 1'b1;
          if (sof && stop_now)        state_q <= ST_IDLE;
          else if (accept)            state_q <= after_accept;
        end
        default:                      state_q <= ST_IDLE;
      endcase
    end
  end

  dvp_axis_out_reg u_out_reg (
    .clk_i   (pclk),
    .rst_ni  (aresetn),
    .load_i  (accept),
    .beat_i  (in_beat),
    .ready_i (m_tready),
    .full_o  (ob_full),
    .beat_o  (out_beat)
  );

  assign m_tvalid        = ob_full;
  assign m_tdata         = out_beat.data;
  assign m_tlast         = out_beat.last;
  assign m_tuser         = out_beat.user;
  assign busy            = (state_q != ST_IDLE);
  assign frame_done      = frame_done_q;
  assign frame_count     = frame_count_q;
  assign err_line_len    = err_line_len_q;
  assign err_short_frame = err_short_frame_q;
  assign err_overflow    = err_overflow_q;

endmodule

// File: tb/tb_dvp_capture_ctrl.sv
// Scoreboard bench for dvp_capture_ctrl: expected beats are queued as stimulus
// is driven and popped as the DUT hands them downstream.
module tb_dvp_capture_ctrl;

  localparam int LW = 12;
  localparam int FW = 11;
  localparam int CW = 16;

  logic          pclk = 1'b0;
  logic          aresetn = 1'b1;
  logic [7:0]    s_tdata = '0;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
  logic [7:0]    m_tdata;
  logic          m_tvalid, m_tlast, m_tuser;
  logic          m_tready = 1'b1;
  logic          cmd_start = 1'b0, cmd_stop = 1'b0, cfg_continuous = 1'b0;
  logic [LW-1:0] cfg_line_bytes = LW'(4);
  logic [FW-1:0] cfg_frame_lines = FW'(3);
  logic          err_clr = 1'b0;
  logic          busy, frame_done;
  logic [CW-1:0] frame_count;
  logic          err_line_len, err_short_frame, err_overflow;
`ifdef DVP_CAPTURE_DECIM_EN
  logic [3:0]    cfg_decim = 4'd0;
`endif

  always #5 pclk = ~pclk;

  dvp_capture_ctrl #(.LW(LW), .FW(FW), .CW(CW)) dut (
    .pclk            (pclk),
    .aresetn         (aresetn),
    .s_tdata         (s_tdata),
    .s_tvalid        (s_tvalid),
    .s_tlast         (s_tlast),
    .s_tuser         (s_tuser),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .m_tlast         (m_tlast),
    .m_tuser         (m_tuser),
    .cmd_start       (cmd_start),
    .cmd_stop        (cmd_stop),
    .cfg_continuous  (cfg_continuous),
    .cfg_line_bytes  (cfg_line_bytes),
    .cfg_frame_lines (cfg_frame_lines),
`ifdef DVP_CAPTURE_DECIM_EN
    .cfg_decim       (cfg_decim),
`endif
    .err_clr         (err_clr),
    .busy            (busy),
    .frame_done      (frame_done),
    .frame_count     (frame_count),
    .err_line_len    (err_line_len),
    .err_short_frame (err_short_frame),
    .err_overflow    (err_overflow)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  int         fd_cnt = 0;
  int         exp_fc = 0;
  int         fd0 = 0;
  int         beat_no = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_got, mon_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge pclk) begin
    if (aresetn && m_tvalid && m_tready) begin
      mon_got = {m_tdata, m_tlast, m_tuser};
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {22'd0, mon_got}, 32'hFFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_beat", {22'd0, mon_got}, {22'd0, mon_exp});
        $display("beat %0d: data=%02h last=%0b user=%0b", beat_no, m_tdata, m_tlast, m_tuser);
        beat_no++;
      end
    end
    if (aresetn && frame_done) fd_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input logic user,
                           input logic exp, input logic stop);
    s_tdata  = d;
    s_tlast  = last;
    s_tuser  = user;
    s_tvalid = 1'b1;
    cmd_stop = stop;
    if (exp) exp_q.push_back({d, last, user});
    @(posedge pclk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    cmd_stop = 1'b0;
  endtask

  task automatic send_idx(input int fid, input int i, input int bpl, input logic exp, input logic stop);
    send_beat(8'(fid * 16 + i), (i % bpl) == bpl - 1, i == 0, exp, stop);
  endtask

  task automatic send_frame(input int fid, input int lines, input int bpl, input logic exp, input int stop_at);
    for (int i = 0; i < lines * bpl; i++) send_idx(fid, i, bpl, exp, i == stop_at);
  endtask

  task automatic pulse_start();
    cmd_start = 1'b1;
    idle(1);
    cmd_start = 1'b0;
  endtask

  task automatic pulse_stop();
    cmd_stop = 1'b1;
    idle(1);
    cmd_stop = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1);
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

  initial begin
    #2 aresetn = 1'b0;
    idle(3);
    check("rst_busy", busy, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_err_line_len", err_line_len, 0);
    check("rst_err_short", err_short_frame, 0);
    check("rst_err_overflow", err_overflow, 0);
    aresetn = 1'b1;
    idle(2);

    // Single shot: first frame captured, second dropped.
    cfg_continuous = 1'b0;
    pulse_start();
    check("t1_busy_armed", busy, 1);
    fd0 = fd_cnt;
    send_frame(1, 3, 4, 1'b1, -1);
    send_frame(2, 3, 4, 1'b0, -1);
    idle(3);
    drain("t1_drain");
    exp_fc += 1;
    check("t1_frame_done", fd_cnt - fd0, 1);
    check("t1_frame_count", frame_count, exp_fc);
    check("t1_busy_after", busy, 0);

    // Continuous with stop during the third frame.
    cfg_continuous = 1'b1;
    pulse_start();
    fd0 = fd_cnt;
    send_frame(3, 3, 4, 1'b1, -1);
    send_frame(4, 3, 4, 1'b1, -1);
    send_frame(5, 3, 4, 1'b1, 6);
    send_frame(6, 3, 4, 1'b0, -1);
    idle(3);
    drain("t2_drain");
    exp_fc += 3;
    check("t2_frame_done", fd_cnt - fd0, 3);
    check("t2_frame_count", frame_count, exp_fc);
    check("t2_busy_after", busy, 0);

    // First line five bytes long.
    cfg_continuous = 1'b0;
    pulse_start();
    fd0 = fd_cnt;
    for (int i = 0; i < 13; i++)
      send_beat(8'(8'h70 + i), i == 4 || i == 8 || i == 12, i == 0, 1'b1, 1'b0);
    idle(3);
    drain("t3_drain");
    exp_fc += 1;
    check("t3_err_line_len", err_line_len, 1);
    check("t3_err_short", err_short_frame, 0);
    check("t3_err_overflow", err_overflow, 0);
    check("t3_frame_done", fd_cnt - fd0, 1);
    check("t3_frame_count", frame_count, exp_fc);
    pulse_clr();
    check("t3_err_cleared", err_line_len, 0);

    // SOF after two of three lines.
    pulse_start();
    fd0 = fd_cnt;
    for (int i = 0; i < 8; i++) send_idx(8, i, 4, 1'b1, 1'b0);
    send_frame(9, 3, 4, 1'b1, -1);
    idle(3);
    drain("t4_drain");
    exp_fc += 1;
    check("t4_err_short", err_short_frame, 1);
    check("t4_frame_done", fd_cnt - fd0, 1);
    check("t4_frame_count", frame_count, exp_fc);
    check("t4_busy_after", busy, 0);
    pulse_clr();
    check("t4_err_cleared", err_short_frame, 0);

    // Downstream stalls two beats mid-line.
    pulse_start();
    fd0 = fd_cnt;
    for (int i = 0; i < 3; i++) send_idx(10, i, 4, 1'b1, 1'b0);
    m_tready = 1'b0;
    send_idx(10, 3, 4, 1'b0, 1'b0);
    @(negedge pclk);
    check("t5_hold_valid_a", m_tvalid, 1);
    check("t5_hold_data_a", m_tdata, 8'hA2);
    @(posedge pclk);
    #1;
    send_idx(10, 4, 4, 1'b0, 1'b0);
    @(negedge pclk);
    check("t5_hold_valid_b", m_tvalid, 1);
    check("t5_hold_data_b", m_tdata, 8'hA2);
    check("t5_err_overflow", err_overflow, 1);
    check("t5_busy_abort", busy, 1);
    @(posedge pclk);
    #1;
    m_tready = 1'b1;
    for (int i = 5; i < 12; i++) send_idx(10, i, 4, 1'b0, 1'b0);
    send_frame(11, 3, 4, 1'b1, -1);
    idle(3);
    drain("t5_drain");
    exp_fc += 1;
    check("t5_frame_done", fd_cnt - fd0, 1);
    check("t5_frame_count", frame_count, exp_fc);
    check("t5_busy_after", busy, 0);
    check("t5_err_line_len", err_line_len, 0);
    pulse_clr();

`ifdef DVP_CAPTURE_DECIM_EN
    // Decimation: one of every three frames.
    cfg_decim = 4'd2;
    cfg_continuous = 1'b1;
    pulse_start();
    fd0 = fd_cnt;
    for (int f = 0; f < 6; f++) send_frame(12 + f, 3, 4, f == 0 || f == 3, -1);
    idle(3);
    drain("t6_drain");
    exp_fc += 2;
    check("t6_frame_done", fd_cnt - fd0, 2);
    check("t6_frame_count", frame_count, exp_fc);
    pulse_stop();
    check("t6_busy_after_stop", busy, 0);
    cfg_continuous = 1'b0;
`endif

    // Reset in the middle of a frame.
    pulse_start();
    send_idx(13, 0, 4, 1'b1, 1'b0);
    send_idx(13, 1, 4, 1'b1, 1'b0);
    send_idx(13, 2, 4, 1'b0, 1'b0);
    aresetn = 1'b0;
    #1;
    check("t7_rst_m_tvalid", m_tvalid, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_frame_count", frame_count, 0);
    @(posedge pclk);
    #1;
    aresetn = 1'b1;
    idle(3);
    check("t7_no_partial", m_tvalid, 0);
    drain("t7_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
